sound_player: RTL and testbench

- Audio back-end for the racing game. Steps a sample address through the song ROM at a fixed sample rate and latches each 4-bit sample.
- Drives a 1-bit PWM audio pin from the latched sample.
- Consumes the game's collision flag: a crash stops the music and rewinds the song to the start.
- Sits downstream of the top-level game logic and beside the song ROM. The ROM is external to this block, combinational, with 1-cycle use.

---
 rtl/game_pkg.sv | 8 +
 rtl/sound_player_if.sv | 16 +
 rtl/sound_player_pwm_dac.sv | 21 ++
 rtl/sound_player.sv | 66 ++++++
 tb/tb_sound_player.sv | 131 +++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: state encoding and default song/timing constants shared by the audio path and the song ROM
package game_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HALT = 2'd2} play_state_t;
   localparam int DEF_SONG_LEN   = 25196;
   localparam int DEF_SAMPLE_DIV = 1563;
   localparam int DEF_ADDR_W     = 15;
   localparam int DEF_DATA_W     = 4;
endpackage

// File: rtl/sound_player_if.sv
// sound_player_if: game control, song ROM and audio signals of the sound player
interface sound_player_if import game_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              start;
   logic              collision;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] sample;
   logic              pwm_out;
   logic              playing;
   logic              song_end;
   modport master (output start, collision, rom_data, input rom_addr, sample, pwm_out, playing, song_end);
   modport slave  (input start, collision, rom_data, output rom_addr, sample, pwm_out, playing, song_end);
endinterface

// File: rtl/sound_player_pwm_dac.sv
// pwm_dac: free-running counter compared against the sample level to make a 1-bit PWM output
module pwm_dac import game_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk50mhz,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] level,
   output logic              pwm_out
);
   logic [DATA_W-1:0] pwm_cnt;
   always_ff @(posedge clk50mhz) begin
      if (!reset) begin
         pwm_cnt <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + DATA_W'(1);
         pwm_out <= en && (pwm_cnt < level);
      end
   end
endmodule

// File: rtl/sound_player.sv
// sound_player: steps through the song ROM at the sample rate, latches samples and drives PWM audio
module sound_player import game_pkg::*; #(
   parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
   parameter int SONG_LEN   = DEF_SONG_LEN,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W
) (
   input logic          clk50mhz,
   input logic          reset,
   sound_player_if.slave bus
);
   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [ADDR_W:0] ADDR_END = (ADDR_W + 1)'(SONG_LEN);
   play_state_t      state, state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [ADDR_W:0]  addr_inc;
   logic             fetch, tick, enter, wrap;
   always_comb begin
      tick      = (state == PLAY) && (div_cnt == DIV_MAX);
      enter     = (state != PLAY) && bus.start;
      addr_inc  = {1'b0, bus.rom_addr} + (ADDR_W + 1)'(1);
      wrap      = addr_inc == ADDR_END;
      state_nxt = bus.collision ? HALT : enter ? PLAY : state;
   end
   always_ff @(posedge clk50mhz) begin
      if (!reset) begin
         state        <= IDLE;
         bus.rom_addr <= '0;
         bus.sample   <= '0;
         bus.song_end <= 1'b0;
         div_cnt      <= '0;
         fetch        <= 1'b0;
      end else begin
         state        <= state_nxt;
         bus.song_end <= 1'b0;
         if (bus.collision) begin
            bus.rom_addr <= '0;
            bus.sample   <= '0;
            div_cnt      <= '0;
            fetch        <= 1'b0;
         end else if (enter) begin
            bus.rom_addr <= '0;
            div_cnt      <= '0;
            fetch        <= 1'b1;
         end else if (state == PLAY) begin
            fetch   <= tick;
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (fetch) bus.sample <= bus.rom_data;
            if (tick) begin
               bus.rom_addr <= wrap ? '0 : addr_inc[ADDR_W-1:0];
               bus.song_end <= wrap;
            end
         end
      end
   end
   assign bus.playing = state == PLAY;
   // gating on collision keeps the pin low from the very cycle HALT is entered
   pwm_dac #(.DATA_W(DATA_W)) u_pwm (
      .clk50mhz(clk50mhz),
      .reset   (reset),
      .en      ((state == PLAY) && !bus.collision),
      .level   (bus.sample),
      .pwm_out (bus.pwm_out)
   );
endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: directed checks of playback, wrap, collision, PWM duty and reset (SAMPLE_DIV=4, SONG_LEN=5)
module tb_sound_player;
   logic       clk50mhz = 1'b0;
   logic       reset = 1'b0;
   logic       force_en = 1'b0;
   logic [3:0] force_val = 4'd0;
   int         total = 0;
   int         bad = 0;
   int         ones;
   always #5 clk50mhz = ~clk50mhz;
   sound_player_if #(.ADDR_W(15), .DATA_W(4)) bus ();
   assign bus.rom_data = force_en ? force_val : 4'(bus.rom_addr + 15'd3);
   sound_player #(.SAMPLE_DIV(4), .SONG_LEN(5), .ADDR_W(15), .DATA_W(4)) dut (
      .clk50mhz(clk50mhz),
      .reset   (reset),
      .bus     (bus.slave)
   );
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk50mhz);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic count_pwm();
      ones = 0;
      repeat (16) begin
         step(1);
         ones += 32'(bus.pwm_out);
      end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.collision = 1'b0;
      step(3);
      chk("rst_addr", 32'(bus.rom_addr), 0);
      chk("rst_sample", 32'(bus.sample), 0);
      chk("rst_pwm", 32'(bus.pwm_out), 0);
      chk("rst_playing", 32'(bus.playing), 0);
      chk("rst_song_end", 32'(bus.song_end), 0);
      reset = 1'b1;
      step(1);
      chk("idle_playing", 32'(bus.playing), 0);
      bus.start = 1'b1;
      step(1);
      chk("entry_playing", 32'(bus.playing), 1);
      chk("entry_addr", 32'(bus.rom_addr), 0);
      bus.start = 1'b0;
      step(1);
      chk("first_sample", 32'(bus.sample), 3);
      step(2);
      chk("addr0_hold", 32'(bus.rom_addr), 0);
      step(1);
      chk("addr1", 32'(bus.rom_addr), 1);
      chk("sample_lag", 32'(bus.sample), 3);
      step(1);
      chk("sample4", 32'(bus.sample), 4);
      step(3);
      chk("addr2", 32'(bus.rom_addr), 2);
      step(8);
      chk("addr4", 32'(bus.rom_addr), 4);
      step(3);
      chk("last_addr_hold", 32'(bus.rom_addr), 4);
      chk("no_end_early", 32'(bus.song_end), 0);
      step(1);
      chk("wrap_addr", 32'(bus.rom_addr), 0);
      chk("song_end_pulse", 32'(bus.song_end), 1);
      step(1);
      chk("song_end_clear", 32'(bus.song_end), 0);
      chk("wrap_sample", 32'(bus.sample), 3);
      step(3);
      chk("loop_addr1", 32'(bus.rom_addr), 1);
      step(7);
      chk("pre_crash_addr", 32'(bus.rom_addr), 2);
      bus.collision = 1'b1;
      step(1);
      chk("crash_playing", 32'(bus.playing), 0);
      chk("crash_addr", 32'(bus.rom_addr), 0);
      chk("crash_sample", 32'(bus.sample), 0);
      chk("crash_pwm", 32'(bus.pwm_out), 0);
      chk("crash_song_end", 32'(bus.song_end), 0);
      bus.start = 1'b1;
      step(3);
      chk("halt_hold_playing", 32'(bus.playing), 0);
      chk("halt_hold_addr", 32'(bus.rom_addr), 0);
      chk("halt_hold_pwm", 32'(bus.pwm_out), 0);
      bus.collision = 1'b0;
      step(1);
      chk("resume_playing", 32'(bus.playing), 1);
      chk("resume_addr", 32'(bus.rom_addr), 0);
      bus.start = 1'b0;
      force_en = 1'b1;
      force_val = 4'd3;
      step(1);
      chk("resume_sample", 32'(bus.sample), 3);
      count_pwm();
      chk("pwm_duty3", 32'(ones), 3);
      force_val = 4'd15;
      step(8);
      chk("sample15", 32'(bus.sample), 15);
      count_pwm();
      chk("pwm_duty15", 32'(ones), 15);
      force_val = 4'd0;
      step(8);
      chk("sample0", 32'(bus.sample), 0);
      count_pwm();
      chk("pwm_duty0", 32'(ones), 0);
      force_en = 1'b0;
      step(10);
      reset = 1'b0;
      step(1);
      chk("mid_rst_addr", 32'(bus.rom_addr), 0);
      chk("mid_rst_sample", 32'(bus.sample), 0);
      chk("mid_rst_pwm", 32'(bus.pwm_out), 0);
      chk("mid_rst_playing", 32'(bus.playing), 0);
      chk("mid_rst_song_end", 32'(bus.song_end), 0);
      reset = 1'b1;
      step(6);
      chk("post_rst_playing", 32'(bus.playing), 0);
      chk("post_rst_addr", 32'(bus.rom_addr), 0);
      chk("post_rst_sample", 32'(bus.sample), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
